mc8051_phase_seq: RTL and testbench

- Machine-cycle phase sequencer and fetch-buffer stage directly upstream of op_decoder.
- Generates the 12-phase timing code consumed as i_t_p_d, and drives the memory read handshake for the opcode fetch (S1), operand 1 fetch (S2) and operand 2 fetch (S3).
- Latches the opcode into the instruction buffer and operands into the S2/S3 data buffers.
- Sequences multi-machine-cycle instructions and inserts wait states on slow memory.

---
 rtl/mc8051_phase_seq.sv | 215 +++++++++++++++++++++
 tb/tb_mc8051_phase_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mc8051_phase_seq.sv
// mc8051_phase_seq: machine-cycle phase sequencer and fetch-buffer stage.
// Generates the 12-phase timing code (S1_0..S6_1), runs the memory read
// handshake for the opcode (S1), operand 1 (S2) and operand 2 (S3) fetches,
// latches the fetched bytes and sequences multi-machine-cycle instructions.
// Optional feature: define MC8051_PHASE_TIMEOUT_EN to bound wait states to
// TIMEOUT_CYC clocks; an expired read loads 8'hFF and pulses o_bus_timeout.
module mc8051_phase_seq #(
    parameter int MC_CNT_W    = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_hold,
    input  logic                i_mem_ready,
    input  logic [7:0]          i_mem_rdata,
    input  logic                i_is_s2_fetch,
    input  logic                i_is_s3_fetch,
    input  logic                i_is_multi_cycles,
    output logic [3:0]          o_t_p_d,
    output logic                o_mem_rd_req,
    output logic [1:0]          o_mem_slot,
    output logic [7:0]          o_instr_buf,
    output logic [7:0]          o_s2_data_buf,
    output logic [7:0]          o_s3_data_buf,
    output logic [MC_CNT_W-1:0] o_mc_cnt,
    output logic                o_instr_start,
    output logic                o_instr_end,
    output logic                o_bus_timeout
);

    typedef enum logic [3:0] {
        S1_0 = 4'd0,  S1_1 = 4'd1,
        S2_0 = 4'd2,  S2_1 = 4'd3,
        S3_0 = 4'd4,  S3_1 = 4'd5,
        S4_0 = 4'd6,  S4_1 = 4'd7,
        S5_0 = 4'd8,  S5_1 = 4'd9,
        S6_0 = 4'd10, S6_1 = 4'd11
    } phase_t;

    localparam logic [1:0] SLOT_OP = 2'b00;
    localparam logic [1:0] SLOT_S2 = 2'b01;
    localparam logic [1:0] SLOT_S3 = 2'b10;

    // Counter saturates here; an instruction can never exceed 2^MC_CNT_W cycles.
    localparam logic [MC_CNT_W-1:0] MC_MAX = '1;

    // Reject configurations that cannot work at elaboration time.
    if (MC_CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mc8051_phase_seq: MC_CNT_W and TIMEOUT_CYC must be >= 1");
    end

    // Registered state and its next-state values
    phase_t              phase, phase_nxt;
    logic                fetch_op, fetch_op_nxt;
    logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nxt;
    logic [7:0]          instr_buf, instr_buf_nxt;
    logic [7:0]          s2_buf, s2_buf_nxt;
    logic [7:0]          s3_buf, s3_buf_nxt;
    logic                instr_start, instr_start_nxt;
    logic                instr_end, instr_end_nxt;

    // Handshake decode
    logic       need_fetch;
    logic [1:0] slot_sel;
    logic       expired;
    logic       advance;
    logic       capture;
    logic [7:0] cap_data;

    // Request decode: a _0 phase requests when its fetch flag is set. Reset and
    // hold both gate the request so nothing is issued while frozen.
    always_comb begin
        need_fetch = 1'b0;
        slot_sel   = SLOT_OP;
        case (phase)
            S1_0: begin
                need_fetch = fetch_op;
                slot_sel   = SLOT_OP;
            end
            S2_0: begin
                need_fetch = i_is_s2_fetch;
                slot_sel   = SLOT_S2;
            end
            S3_0: begin
                need_fetch = i_is_s3_fetch;
                slot_sel   = SLOT_S3;
            end
            default: ;
        endcase
        o_mem_rd_req = reset_n & ~i_hold & need_fetch;
        o_mem_slot   = o_mem_rd_req ? slot_sel : 2'b00;
    end

`ifdef MC8051_PHASE_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              bus_to, bus_to_nxt;

    // The read is abandoned on the clock that would be the TIMEOUT_CYC-th wait.
    assign expired = o_mem_rd_req & ~i_mem_ready &
                     (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    // Wait counter: zero on every phase advance (so zero on entry to each _0),
    // counts stalled request clocks, frozen under hold.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        bus_to_nxt   = expired;
        if (!i_hold) begin
            if (advance)
                wait_cnt_nxt = '0;
            else if (o_mem_rd_req)
                wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    // Wait counter and timeout pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            bus_to   <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            bus_to   <= bus_to_nxt;
        end
    end

    assign o_bus_timeout = bus_to;
`else
    assign expired       = 1'b0;
    assign o_bus_timeout = 1'b0;
`endif

    // A phase advances unless held or stalled on a request without ready.
    // A request completes on ready, or on timeout with the 8'hFF filler.
    assign advance  = ~i_hold & (~o_mem_rd_req | i_mem_ready | expired);
    assign capture  = o_mem_rd_req & (i_mem_ready | expired);
    assign cap_data = i_mem_ready ? i_mem_rdata : 8'hFF;

    // Next-state: phase stepping, buffer capture, machine-cycle bookkeeping
    always_comb begin
        phase_nxt       = phase;
        fetch_op_nxt    = fetch_op;
        mc_cnt_nxt      = mc_cnt;
        instr_buf_nxt   = instr_buf;
        s2_buf_nxt      = s2_buf;
        s3_buf_nxt      = s3_buf;
        instr_start_nxt = 1'b0;
        instr_end_nxt   = 1'b0;

        if (advance) begin
            phase_nxt = (phase == S6_1) ? S1_0 : phase_t'(phase + 4'd1);

            if (capture) begin
                case (phase)
                    S1_0: begin
                        instr_buf_nxt   = cap_data;
                        instr_start_nxt = 1'b1;
                    end
                    S2_0:    s2_buf_nxt = cap_data;
                    S3_0:    s3_buf_nxt = cap_data;
                    default: ;
                endcase
            end

            // Registered end pulse must already be high during S6_1, so the
            // termination decision is taken on the edge into S6_1.
            if (phase == S6_0 && (!i_is_multi_cycles || mc_cnt == MC_MAX))
                instr_end_nxt = 1'b1;

            // Leaving S6_1: continue the instruction or terminate it.
            if (phase == S6_1) begin
                if (i_is_multi_cycles && mc_cnt != MC_MAX) begin
                    mc_cnt_nxt   = mc_cnt + 1'b1;
                    fetch_op_nxt = 1'b0;
                end else begin
                    mc_cnt_nxt   = '0;
                    fetch_op_nxt = 1'b1;
                end
            end
        end
    end

    // State registers; asynchronous reset abandons any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= S1_0;
            fetch_op    <= 1'b1;
            mc_cnt      <= '0;
            instr_buf   <= 8'h00;
            s2_buf      <= 8'h00;
            s3_buf      <= 8'h00;
            instr_start <= 1'b0;
            instr_end   <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            fetch_op    <= fetch_op_nxt;
            mc_cnt      <= mc_cnt_nxt;
            instr_buf   <= instr_buf_nxt;
            s2_buf      <= s2_buf_nxt;
            s3_buf      <= s3_buf_nxt;
            instr_start <= instr_start_nxt;
            instr_end   <= instr_end_nxt;
        end
    end

    assign o_t_p_d       = phase;
    assign o_instr_buf   = instr_buf;
    assign o_s2_data_buf = s2_buf;
    assign o_s3_data_buf = s3_buf;
    assign o_mc_cnt      = mc_cnt;
    assign o_instr_start = instr_start;
    assign o_instr_end   = instr_end;

endmodule

// File: tb/tb_mc8051_phase_seq.sv
// Bench for mc8051_phase_seq: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mc8051_phase_seq;
    localparam int MC_W    = 2;
    localparam int MC_MAXV = (1 << MC_W) - 1;
    localparam int TO_CYC  = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            i_hold = 1'b0;
    logic            i_mem_ready = 1'b0;
    logic [7:0]      i_mem_rdata = 8'h00;
    logic            i_is_s2_fetch = 1'b0;
    logic            i_is_s3_fetch = 1'b0;
    logic            i_is_multi_cycles = 1'b0;
    logic [3:0]      o_t_p_d;
    logic            o_mem_rd_req;
    logic [1:0]      o_mem_slot;
    logic [7:0]      o_instr_buf, o_s2_data_buf, o_s3_data_buf;
    logic [MC_W-1:0] o_mc_cnt;
    logic            o_instr_start, o_instr_end, o_bus_timeout;

    int errs = 0;
    int checks = 0;

    mc8051_phase_seq #(.MC_CNT_W(MC_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .i_hold(i_hold),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
        .i_is_s2_fetch(i_is_s2_fetch), .i_is_s3_fetch(i_is_s3_fetch),
        .i_is_multi_cycles(i_is_multi_cycles),
        .o_t_p_d(o_t_p_d), .o_mem_rd_req(o_mem_rd_req), .o_mem_slot(o_mem_slot),
        .o_instr_buf(o_instr_buf), .o_s2_data_buf(o_s2_data_buf),
        .o_s3_data_buf(o_s3_data_buf), .o_mc_cnt(o_mc_cnt),
        .o_instr_start(o_instr_start), .o_instr_end(o_instr_end),
        .o_bus_timeout(o_bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase is a number 0..11; stage = phase/2 (S1..S6), even phases are _0.
    // Stages 0..2 may fetch into buffer[stage]; stage 0 is the opcode.
    int         m_ph = 0;
    bit         m_fop = 1'b1;
    int         m_mc = 0;
    logic [7:0] m_buf [3] = '{8'h00, 8'h00, 8'h00};
    bit         m_st = 1'b0, m_en = 1'b0, m_to = 1'b0;
    int         m_wait = 0;

    function automatic bit wants(int stage);
        case (stage)
            0: return m_fop;
            1: return i_is_s2_fetch;
            2: return i_is_s3_fetch;
            default: return 1'b0;
        endcase
    endfunction

    // Single compare process: outputs are checked mid-cycle, then the model
    // steps to what the coming rising edge must produce.
    always @(negedge clk) begin
        bit req_e, adv, tout;
        int slot_e;
        #2;
        if (!reset_n) begin
            m_ph = 0; m_fop = 1'b1; m_mc = 0;
            m_buf = '{8'h00, 8'h00, 8'h00};
            m_st = 1'b0; m_en = 1'b0; m_to = 1'b0; m_wait = 0;
        end
        req_e  = reset_n && !i_hold && (m_ph % 2 == 0) && (m_ph <= 4) && wants(m_ph / 2);
        slot_e = req_e ? m_ph / 2 : 0;

        chk("t_p_d", o_t_p_d, m_ph);
        chk("rd_req", o_mem_rd_req, req_e);
        chk("slot", o_mem_slot, slot_e);
        chk("instr_buf", o_instr_buf, m_buf[0]);
        chk("s2_buf", o_s2_data_buf, m_buf[1]);
        chk("s3_buf", o_s3_data_buf, m_buf[2]);
        chk("mc_cnt", o_mc_cnt, m_mc);
        chk("instr_start", o_instr_start, m_st);
        chk("instr_end", o_instr_end, m_en);
        chk("bus_timeout", o_bus_timeout, m_to);

        if (reset_n) begin
            m_st = 1'b0; m_en = 1'b0; m_to = 1'b0;
            if (!i_hold) begin
                adv  = 1'b1;
                tout = 1'b0;
                if (req_e && !i_mem_ready) begin
`ifdef MC8051_PHASE_TIMEOUT_EN
                    if (m_wait == TO_CYC - 1) tout = 1'b1;
                    else begin m_wait++; adv = 1'b0; end
`else
                    adv = 1'b0;
`endif
                end
                if (adv) begin
                    if (req_e) begin
                        m_buf[m_ph / 2] = i_mem_ready ? i_mem_rdata : 8'hFF;
                        if (m_ph == 0) m_st = 1'b1;
                    end
                    m_to = tout;
                    if (m_ph == 10 && (!i_is_multi_cycles || m_mc == MC_MAXV)) m_en = 1'b1;
                    if (m_ph == 11) begin
                        if (i_is_multi_cycles && m_mc < MC_MAXV) begin m_mc++; m_fop = 1'b0; end
                        else begin m_mc = 0; m_fop = 1'b1; end
                    end
                    m_ph   = (m_ph + 1) % 12;
                    m_wait = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One clock of inputs applied at the falling edge; returns after the
    // model check so directed checks see the same settled outputs.
    task automatic step(input bit rdy, input logic [7:0] d, input bit s2, input bit s3,
                        input bit multi, input bit hold);
        @(negedge clk);
        i_mem_ready = rdy; i_mem_rdata = d; i_is_s2_fetch = s2;
        i_is_s3_fetch = s3; i_is_multi_cycles = multi; i_hold = hold;
        #3;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req", o_mem_rd_req, 0);
        chk("rst_phase", o_t_p_d, 0);

        // Scenario 1: opcode 04, zero wait, single cycle
        @(negedge clk);
        reset_n = 1'b1; i_mem_ready = 1'b1; i_mem_rdata = 8'h04;
        #3;
        chk("s1_req_first", o_mem_rd_req, 1);
        chk("s1_slot_first", o_mem_slot, 0);
        chk("s1_instr_rst", o_instr_buf, 8'h00);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s1_phase1", o_t_p_d, 1);
        chk("s1_instr04", o_instr_buf, 8'h04);
        chk("s1_start", o_instr_start, 1);
        repeat (10) step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s1_phase11", o_t_p_d, 11);
        chk("s1_end", o_instr_end, 1);

        // Scenario 2: opcode 74 with S2 operand 5A after 3 wait clocks
        step(1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s2_refetch_req", o_mem_rd_req, 1);
        step(1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s2_instr74", o_instr_buf, 8'h74);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("s2_wait_phase", o_t_p_d, 2);
            chk("s2_wait_slot", o_mem_slot, 1);
        end
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s2_last_wait", o_t_p_d, 2);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s2_phase3", o_t_p_d, 3);
        chk("s2_data5A", o_s2_data_buf, 8'h5A);

        // Scenario 3: multi held high saturates the counter, then terminates
        n = 0;
        while (o_mc_cnt != MC_W'(MC_MAXV) && n < 200) begin
            step(1'b1, 8'(n), 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("mc_reach_max", o_mc_cnt, MC_MAXV);
        n = 0;
        while (!o_instr_end && n < 60) begin
            step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("mc_max_end", o_instr_end, 1);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mc_no_wrap", o_mc_cnt, 0);
        chk("mc_refetch", o_mem_rd_req, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clk); reset_n = 1'b0;
                @(negedge clk); reset_n = 1'b1;
            end
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
